// File: rtl/neon_control_unit.sv
// Multi-cycle control unit for a 16-bit accumulator-free RISC core: FETCH/DECODE/EXECUTE/WRITEBACK
// sequencer that owns the pc, the instruction register and the Z/P condition latches.
module neon_control_unit (
    input  logic        clock,
    input  logic        reset,
    output logic [7:0]  pc,
    output logic        fetch_req,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        rf_write,
    output logic [2:0]  rs_addr,
    output logic [2:0]  rt_addr,
    output logic [2:0]  rd_addr,
    output logic [15:0] imm_data,
    output logic [3:0]  alu_sel,
    output logic        imm_sel,
    output logic        mem_write,
    output logic        mem_sel,
    input  logic        zero_flag,
    input  logic        pos_flag,
    output logic        halted
);

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK,
        ST_HALT
    } state_t;

    typedef enum logic [1:0] {
        BR_NONE,
        BR_ZERO,
        BR_POS,
        BR_ALWAYS
    } branch_t;

    localparam logic [4:0] OP_LOAD  = 5'b10000;
    localparam logic [4:0] OP_STORE = 5'b10001;
    localparam logic [4:0] OP_MOVI  = 5'b10110;
    localparam logic [4:0] OP_BZ    = 5'b11000;
    localparam logic [4:0] OP_BP    = 5'b11001;
    localparam logic [4:0] OP_JMP   = 5'b11010;
    localparam logic [4:0] OP_HALT  = 5'b11111;

    state_t      state_reg, state_next;
    logic [7:0]  pc_reg, pc_next;
    logic [15:0] ir_reg;
    logic        z_reg, p_reg;

    logic [2:0]  rd_reg, rs_reg, rt_reg;
    logic [3:0]  alu_sel_reg;
    logic        imm_sel_reg, mem_sel_reg;
    logic [15:0] imm_data_reg;
    logic        wr_en_reg, store_reg, flag_en_reg;
    branch_t     branch_reg;

    logic [4:0]  op;
    logic [3:0]  dec_alu_sel;
    logic        dec_imm_sel, dec_mem_sel, dec_wr_en, dec_store, dec_flag_en, dec_halt;
    logic [2:0]  dec_rs;
    logic [15:0] dec_imm_data;
    branch_t     dec_branch;
    logic        branch_taken;

    assign op = ir_reg[15:11];

    // Instruction decode from IR; anything not listed falls through as a NOP.
    always_comb begin
        dec_alu_sel  = 4'h0;
        dec_imm_sel  = 1'b0;
        dec_mem_sel  = 1'b0;
        dec_wr_en    = 1'b0;
        dec_store    = 1'b0;
        dec_flag_en  = 1'b0;
        dec_halt     = 1'b0;
        dec_rs       = ir_reg[7:5];
        dec_imm_data = 16'h0000;
        dec_branch   = BR_NONE;
        if (op[4] == 1'b0) begin
            if (op != 5'b00000) begin
                dec_alu_sel = op[3:0];
                dec_wr_en   = 1'b1;
                dec_flag_en = 1'b1;
            end
        end else begin
            case (op)
                OP_MOVI: begin
                    dec_alu_sel  = 4'b1011;
                    dec_imm_sel  = 1'b1;
                    dec_imm_data = {8'h00, ir_reg[7:0]};
                    dec_rs       = ir_reg[2:0];
                    dec_wr_en    = 1'b1;
                    dec_flag_en  = 1'b1;
                end
                OP_LOAD: begin
                    dec_mem_sel = 1'b1;
                    dec_wr_en   = 1'b1;
                end
                OP_STORE: dec_store  = 1'b1;
                OP_BZ:    dec_branch = BR_ZERO;
                OP_BP:    dec_branch = BR_POS;
                OP_JMP:   dec_branch = BR_ALWAYS;
                OP_HALT:  dec_halt   = 1'b1;
                default:  ;
            endcase
        end
    end

    assign branch_taken = (branch_reg == BR_ALWAYS) ||
                          ((branch_reg == BR_ZERO) && z_reg) ||
                          ((branch_reg == BR_POS) && p_reg);

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        case (state_reg)
            ST_FETCH:     if (instr_valid) state_next = ST_DECODE;
            ST_DECODE:    state_next = dec_halt ? ST_HALT : ST_EXECUTE;
            ST_EXECUTE:   state_next = ST_WRITEBACK;
            ST_WRITEBACK: begin
                state_next = ST_FETCH;
                pc_next    = branch_taken ? ir_reg[7:0] : pc_reg + 8'd1;
            end
            ST_HALT:      state_next = ST_HALT;
            default:      state_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg    <= ST_FETCH;
            pc_reg       <= 8'h00;
            ir_reg       <= 16'h0000;
            z_reg        <= 1'b0;
            p_reg        <= 1'b0;
            rd_reg       <= 3'd0;
            rs_reg       <= 3'd0;
            rt_reg       <= 3'd0;
            alu_sel_reg  <= 4'h0;
            imm_sel_reg  <= 1'b0;
            mem_sel_reg  <= 1'b0;
            imm_data_reg <= 16'h0000;
            wr_en_reg    <= 1'b0;
            store_reg    <= 1'b0;
            flag_en_reg  <= 1'b0;
            branch_reg   <= BR_NONE;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            if (state_reg == ST_FETCH && instr_valid) begin
                ir_reg <= instr;
            end
            if (state_reg == ST_DECODE) begin
                rd_reg       <= ir_reg[10:8];
                rs_reg       <= dec_rs;
                rt_reg       <= ir_reg[4:2];
                alu_sel_reg  <= dec_alu_sel;
                imm_sel_reg  <= dec_imm_sel;
                mem_sel_reg  <= dec_mem_sel;
                imm_data_reg <= dec_imm_data;
                wr_en_reg    <= dec_wr_en;
                store_reg    <= dec_store;
                flag_en_reg  <= dec_flag_en;
                branch_reg   <= dec_branch;
            end
            if (state_reg == ST_EXECUTE && flag_en_reg) begin
                z_reg <= zero_flag;
                p_reg <= pos_flag;
            end
        end
    end

    assign pc        = pc_reg;
    assign fetch_req = (state_reg == ST_FETCH);
    assign halted    = (state_reg == ST_HALT);
    assign rd_addr   = rd_reg;
    assign rs_addr   = rs_reg;
    assign rt_addr   = rt_reg;
    assign alu_sel   = alu_sel_reg;
    assign imm_sel   = imm_sel_reg;
    assign mem_sel   = mem_sel_reg;
    assign imm_data  = imm_data_reg;

    // Strobes are masked by reset so a store/write-back caught by reset never lands on that edge.
    assign rf_write  = reset && (state_reg == ST_WRITEBACK) && wr_en_reg;
    assign mem_write = reset && (state_reg == ST_EXECUTE) && store_reg;

endmodule

// File: doc/neon_control_unit.md
NEON_CONTROL_UNIT -- requirements
Module: neon_control_unit

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, all state changes on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-low; sampled only on rising clock edge.
REQ-003 SHALL have: pc  out  8  instruction address; fetch_req  out  1  request instruction at pc.
REQ-004 SHALL have: instr  in  16  instruction word; instr_valid  in  1  instr valid this cycle.
REQ-005 SHALL have datapath drives: rf_write out 1; rs_addr, rt_addr, rd_addr out 3 each; imm_data out 16; alu_sel out 4; imm_sel out 1; mem_write out 1; mem_sel out 1.
REQ-006 SHALL have: zero_flag  in  1, pos_flag  in  1  combinational ALU result flags from datapath.
REQ-007 SHALL have: halted  out  1  high while in HALT state.

Function
REQ-008 SHALL implement states FETCH, DECODE, EXECUTE, WRITEBACK, HALT; one-hot or encoded, not visible externally except via halted.
REQ-009 FETCH: fetch_req=1; stay while instr_valid=0; on instr_valid=1 latch instr into IR and go DECODE.
REQ-010 Fields: op=IR[15:11], rd=IR[10:8], rs=IR[7:5], rt=IR[4:2], imm8=IR[7:0].
REQ-011 DECODE: register rd_addr, rs_addr, rt_addr, alu_sel, imm_sel, mem_sel, imm_data; hold them unchanged through EXECUTE and WRITEBACK; go EXECUTE.
REQ-012 op 00001-01111 (ALU): alu_sel=op[3:0], imm_sel=0, mem_sel=0; rf_write in WRITEBACK.
REQ-013 op 10110 (MOVI): alu_sel=1011, imm_sel=1, imm_data={8'h00,imm8} (zero-extend), rs_addr=imm8[2:0]; rf_write in WRITEBACK.
REQ-014 op 10000 (LOAD rd,[rs]): mem_sel=1, imm_sel=0; rf_write in WRITEBACK.
REQ-015 op 10001 (STORE [rs],rt): mem_write=1 for exactly the EXECUTE cycle; no rf_write.
REQ-016 op 11000 BZ, 11001 BP, 11010 JMP: target=imm8; BZ taken if latched Z=1, BP if latched P=1, JMP always; no rf_write, no mem_write.
REQ-017 op 11111 (HALT): go HALT after DECODE; op 00000 and all undefined ops SHALL behave as NOP (no writes, pc+1).
REQ-018 Z/P latches SHALL capture zero_flag/pos_flag in the EXECUTE cycle of ALU and MOVI ops only; other ops leave them unchanged.
REQ-019 EXECUTE always goes WRITEBACK; WRITEBACK always goes FETCH.
REQ-020 rf_write SHALL be high for exactly one cycle (WRITEBACK) per writing instruction; never high in other states.
REQ-021 pc update occurs at end of WRITEBACK: taken branch -> target, else pc+1 modulo 256 (8'hFF wraps to 8'h00).
REQ-022 Non-stalled instruction latency SHALL be exactly 4 cycles FETCH-to-FETCH; each instr_valid=0 FETCH cycle adds one.
REQ-023 HALT: fetch_req=0, rf_write=0, mem_write=0, pc frozen, halted=1; exit only via reset.
REQ-024 instr_valid outside FETCH SHALL be ignored.

Reset
REQ-025 reset=0 at a rising edge SHALL force state=FETCH, pc=0, IR=0, Z=P=0, all datapath drives and halted to 0, on that edge, overriding any state including mid-instruction and HALT.
REQ-026 A store or write-back interrupted by reset SHALL not complete; first cycle after reset release fetch_req=1 with pc=0.

Verification
REQ-027 Reset then instr 16'hB708 (MOVI R7,#8) with instr_valid=1 -> WRITEBACK on cycle 4: rd_addr=7, alu_sel=1011, imm_sel=1, imm_data=16'h0008, rf_write=1 one cycle; pc=1 next FETCH; datapath R7=16'd8.
REQ-028 instr_valid held low 3 cycles in FETCH -> state stays FETCH, fetch_req=1, pc unchanged, no writes; instruction completes 7 cycles after first fetch_req.
REQ-029 ALU op giving zero_flag=1 then BZ #8'h20 -> pc=8'h20; repeat with zero_flag=0 -> pc increments by 1; JMP #8'h05 -> pc=8'h05 regardless of flags.
REQ-030 STORE 16'h8824 -> mem_write=1 exactly in EXECUTE, rf_write never asserted; LOAD -> mem_sel=1 and rf_write in WRITEBACK.
REQ-031 pc=8'hFF executing NOP -> pc=8'h00; HALT 16'hF800 -> halted=1, fetch_req=0 indefinitely; reset=0 -> pc=0, halted=0.
REQ-032 reset=0 asserted during EXECUTE of a STORE and during WRITEBACK of MOVI -> mem_write and rf_write both 0 on that edge; target register unchanged.
